nt_level_driver: RTL

NT_LEVEL_DRIVER -- requirements
Module: nt_level_driver

---
 rtl/nt_level_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/nt_level_driver.sv
// nt_level_driver: drives an external neurotransmitter resource towards a
// requested level by issuing registered inc/dec/fast step commands, with
// one EVAL cycle after every command to observe the updated level.
module nt_level_driver #(
  parameter int N         = 7,
  parameter int FAST_STEP = 3,
  parameter int MAX_STEPS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         target_valid,
  input  logic [N-1:0] target,
  output logic         target_ready,
  input  logic [N-1:0] current,
  input  logic         abort,
  output logic         inc,
  output logic         dec,
  output logic         fast,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int CW = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_STEPS);
  localparam logic [N:0]    FAST_W = (N + 1)'(FAST_STEP);

  logic [1:0]        state;
  logic [N-1:0]      target_latched;
  logic [CW-1:0]     step_cnt;
  logic signed [N:0] diff;
  logic [N:0]        diff_abs;

  // Signed distance from the observed level to the latched target
  always_comb begin
    diff     = $signed({1'b0, target_latched}) - $signed({1'b0, current});
    diff_abs = diff[N] ? $unsigned(-diff) : $unsigned(diff);
  end

  assign target_ready = (state == IDLE) && rst_n;
  assign busy         = (state == EVAL) || (state == STEP);

  // Request FSM with registered step commands and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      target_latched <= '0;
      step_cnt       <= '0;
      inc            <= 1'b0;
      dec            <= 1'b0;
      fast           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      // Commands and pulses last a single cycle unless re-asserted below
      inc   <= 1'b0;
      dec   <= 1'b0;
      fast  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (target_valid) begin
            target_latched <= target;
            step_cnt       <= '0;
            state          <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            state <= IDLE;
          end else if (diff == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (step_cnt == MAX_C) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            inc   <= ~diff[N];
            dec   <= diff[N];
            fast  <= (diff_abs >= FAST_W);
            if (step_cnt != MAX_C) step_cnt <= step_cnt + 1'b1;
            state <= STEP;
          end
        end
        STEP: begin
          state <= abort ? IDLE : EVAL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
